// File: rtl/ddr_lane_sched.sv
// DDR output lane scheduler: round-robin between two word sources, sends a
// sync/ID header then the payload two bits per clock, idles with a 1/0 pattern.
module ddr_lane_sched #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SYNC  = 16'hA5C2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_in0_valid,
    input  logic [WIDTH-1:0] i_in0_data,
    output logic             o_in0_ready,
    input  logic             i_in1_valid,
    input  logic [WIDTH-1:0] i_in1_data,
    output logic             o_in1_ready,
    output logic             o_d_rise,
    output logic             o_d_fall,
    output logic             o_frame_start,
    output logic             o_busy
);

    localparam int BEATS = WIDTH / 2;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FW    = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t          r_state, w_state_nxt;
    logic [BW-1:0]   r_beat, w_beat_nxt;
    logic            r_last;
    logic [FW-1:0]   r_sh;
    logic [FW-1:0]   w_frame;
    logic            w_last_beat, w_gp, w_gid, w_any;
    logic            w_rise_nxt, w_fall_nxt, w_fs_nxt, w_busy_nxt;

    assign w_last_beat = (r_beat == BW'(BEATS - 1));
    assign w_any       = i_in0_valid | i_in1_valid;
    assign w_gp        = !i_rst && i_en && w_any &&
                         ((r_state == S_IDLE) || ((r_state == S_DATA) && w_last_beat));
    // On a tie the source not granted last wins; otherwise the lone valid one.
    assign w_gid       = (i_in0_valid && i_in1_valid) ? ~r_last : i_in1_valid;
    assign o_in0_ready = w_gp & ~w_gid;
    assign o_in1_ready = w_gp &  w_gid;
    assign w_frame     = {SYNC[WIDTH-1:1], w_gid, (w_gid ? i_in1_data : i_in0_data)};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat + 1'b1;
        case (r_state)
            S_IDLE: begin
                w_beat_nxt = '0;
                if (w_gp) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (w_last_beat) begin
                    w_state_nxt = S_DATA;
                    w_beat_nxt  = '0;
                end
            end
            S_DATA: begin
                if (w_last_beat) begin
                    w_state_nxt = w_gp ? S_HDR : S_IDLE;
                    w_beat_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    // Header beat 0 goes straight out of the grant; later beats come from the shifter.
    always_comb begin
        w_rise_nxt = 1'b1;
        w_fall_nxt = 1'b0;
        w_fs_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
        if (w_gp) begin
            w_rise_nxt = SYNC[WIDTH-1];
            w_fall_nxt = SYNC[WIDTH-2];
            w_fs_nxt   = 1'b1;
            w_busy_nxt = 1'b1;
        end else if (w_state_nxt != S_IDLE) begin
            w_rise_nxt = r_sh[FW-1];
            w_fall_nxt = r_sh[FW-2];
            w_busy_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last        <= 1'b1;
            r_sh          <= '0;
            o_d_rise      <= 1'b0;
            o_d_fall      <= 1'b0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            if (w_gp) begin
                r_last <= w_gid;
                r_sh   <= {w_frame[FW-3:0], 2'b00};
            end else begin
                r_sh   <= {r_sh[FW-3:0], 2'b00};
            end
            o_d_rise      <= w_rise_nxt;
            o_d_fall      <= w_fall_nxt;
            o_frame_start <= w_fs_nxt;
            o_busy        <= w_busy_nxt;
        end
    end

endmodule
